// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control bit positions, arbiter state encoding and named Hack op codes.
package alu_pkg;
  localparam int ZX = 5;
  localparam int NX = 4;
  localparam int ZY = 3;
  localparam int NY = 2;
  localparam int F  = 1;
  localparam int NO = 0;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [5:0] ADD  = 6'b000010;
  localparam logic [5:0] SUB  = 6'b010011;
  localparam logic [5:0] ZERO = 6'b101010;
  localparam logic [5:0] ONE  = 6'b111111;
  localparam logic [5:0] NEG1 = 6'b111010;
endpackage

// File: rtl/alu_optimized.sv
// alu_optimized: combinational Hack ALU; each optional inversion is folded into an XOR mask.
module alu_optimized
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [5:0]       i_ctrl,
  output logic [WIDTH-1:0] o_out,
  output logic             o_zr,
  output logic             o_ng
);
  logic [WIDTH-1:0] w_x, w_y, w_f;
  assign w_x   = (i_ctrl[ZX] ? '0 : i_x) ^ {WIDTH{i_ctrl[NX]}};
  assign w_y   = (i_ctrl[ZY] ? '0 : i_y) ^ {WIDTH{i_ctrl[NY]}};
  assign w_f   = i_ctrl[F] ? w_x + w_y : w_x & w_y;
  assign o_out = w_f ^ {WIDTH{i_ctrl[NO]}};
  assign o_zr  = ~|o_out;
  assign o_ng  = o_out[WIDTH-1];
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbitration of two requesters onto one registered Hack ALU.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [5:0]       req0_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_out,
  output logic             rsp0_zr,
  output logic             rsp0_ng,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [5:0]       req1_ctrl,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_out,
  output logic             rsp1_zr,
  output logic             rsp1_ng,
  output logic             busy,
  output logic             grant_id
);
  state_t           r_state, w_next;
  logic             r_ptr, r_gid, r_zr, r_ng;
  logic [WIDTH-1:0] r_x, r_y, r_out;
  logic [5:0]       r_ctrl;
  logic             w_gnt, w_acc, w_done, w_zr, w_ng;
  logic [WIDTH-1:0] w_out;
  // A lone requester wins outright; the pointer only breaks ties.
  assign w_gnt  = (req0_valid ^ req1_valid) ? req1_valid : r_ptr;
  assign w_acc  = (r_state == IDLE) && (req0_valid || req1_valid);
  assign w_done = (r_state == RESP) && (r_gid ? rsp1_ready : rsp0_ready);
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_acc) w_next = EXEC;
    if (r_state == EXEC) w_next = RESP;
    if (w_done) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 1'(RR_INIT);
      r_gid   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_ctrl  <= '0;
      r_out   <= '0;
      r_zr    <= 1'b0;
      r_ng    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_gid  <= w_gnt;
        r_x    <= w_gnt ? req1_x : req0_x;
        r_y    <= w_gnt ? req1_y : req0_y;
        r_ctrl <= w_gnt ? req1_ctrl : req0_ctrl;
      end
      if (r_state == EXEC) begin
        r_out <= w_out;
        r_zr  <= w_zr;
        r_ng  <= w_ng;
      end
      if (w_done) r_ptr <= ~r_gid;
    end
  end
  alu_optimized #(.WIDTH(WIDTH)) u_alu (
    .i_x   (r_x),
    .i_y   (r_y),
    .i_ctrl(r_ctrl),
    .o_out (w_out),
    .o_zr  (w_zr),
    .o_ng  (w_ng)
  );
  assign busy       = r_state != IDLE;
  assign grant_id   = r_gid;
  assign req0_ready = (r_state == IDLE) && !w_gnt && req0_valid;
  assign req1_ready = (r_state == IDLE) && w_gnt && req1_valid;
  assign rsp0_valid = (r_state == RESP) && !r_gid;
  assign rsp1_valid = (r_state == RESP) && r_gid;
  assign rsp0_out   = r_out;
  assign rsp1_out   = r_out;
  assign rsp0_zr    = r_zr;
  assign rsp1_zr    = r_zr;
  assign rsp0_ng    = r_ng;
  assign rsp1_ng    = r_ng;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
  import alu_pkg::*;
  logic        clk = 0, rst_n = 1;
  logic        v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
  logic [15:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0;
  logic [5:0]  c0 = 0, c1 = 0;
  logic        rdy0, rdy1, rv0, rv1, zr0, zr1, ng0, ng1, busy, gid;
  logic [15:0] out0, out1, hold;
  bit          keep0 = 0, keep1 = 0;
  bit          m_busy = 0, m_own = 0, m_ptr = 0;
  int          m_acc = 0, cyc = 0, checks = 0, errors = 0;
  logic [15:0] m_out = 0;

  alu_arbiter #(.WIDTH(16), .RR_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rdy0), .req0_x(x0), .req0_y(y0), .req0_ctrl(c0),
    .rsp0_valid(rv0), .rsp0_ready(rr0), .rsp0_out(out0), .rsp0_zr(zr0), .rsp0_ng(ng0),
    .req1_valid(v1), .req1_ready(rdy1), .req1_x(x1), .req1_y(y1), .req1_ctrl(c1),
    .rsp1_valid(rv1), .rsp1_ready(rr1), .rsp1_out(out1), .rsp1_zr(zr1), .rsp1_ng(ng1),
    .busy(busy), .grant_id(gid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(logic [15:0] x, logic [15:0] y, logic [5:0] c);
    int a, b, r;
    a = c[5] ? 0 : int'(x);
    b = c[3] ? 0 : int'(y);
    if (c[4]) a = 65535 - a;
    if (c[2]) b = 65535 - b;
    r = c[1] ? (a + b) % 65536 : int'(16'(a) & 16'(b));
    if (c[0]) r = 65535 - r;
    return 16'(r);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit g, e0, e1, on;
    @(negedge clk);
    g  = (v0 ^ v1) ? v1 : m_ptr;
    e0 = !m_busy && v0 && !g;
    e1 = !m_busy && v1 && g;
    on = m_busy && (cyc - m_acc >= 2);
    check("ready0", rdy0, e0);
    check("ready1", rdy1, e1);
    check("busy", busy, m_busy);
    check("rsp0_valid", rv0, on && !m_own);
    check("rsp1_valid", rv1, on && m_own);
    if (m_busy) check("grant_id", gid, m_own);
    if (on) begin
      check("out", m_own ? out1 : out0, m_out);
      check("zr", m_own ? zr1 : zr0, m_out == 0);
      check("ng", m_own ? ng1 : ng0, m_out[15]);
    end
    @(posedge clk);
    if (on && (m_own ? rr1 : rr0)) begin
      m_busy = 0;
      m_ptr  = !m_own;
    end else if (e0 || e1) begin
      m_busy = 1;
      m_own  = e1;
      m_acc  = cyc;
      m_out  = e1 ? ref_alu(x1, y1, c1) : ref_alu(x0, y0, c0);
    end
    cyc++;
    #1;
    if (e0 && !keep0) v0 = 0;
    if (e1 && !keep1) v1 = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rv0", rv0, 0);
    check("rst_rv1", rv1, 0);
    check("rst_gid", gid, 0);
    check("rst_out", out0, 0);
    m_busy = 0;
    m_ptr  = 0;
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    @(posedge clk);
    #1 do_reset();
    // basic add on requester 0
    v0 = 1; x0 = 5; y0 = 3; c0 = ADD;
    #1 check("t1_ready", rdy0, 1);
    cycle(); cycle();
    check("t1_valid", rv0, 1);
    check("t1_out", out0, 16'd8);
    check("t1_zr", zr0, 0);
    check("t1_ng", ng0, 0);
    rr0 = 1;
    cycle();
    // subtract on requester 1 with rsp_ready already high
    v1 = 1; x1 = 3; y1 = 5; c1 = SUB; rr1 = 1;
    cycle(); cycle();
    check("t2_valid", rv1, 1);
    check("t2_out", out1, 16'hFFFE);
    check("t2_ng", ng1, 1);
    check("t2_zr", zr1, 0);
    check("t2_rv0", rv0, 0);
    cycle();
    check("t2_idle", busy, 0);
    // tie-break rotation from a fresh reset
    do_reset();
    v0 = 1; v1 = 1; keep0 = 1; keep1 = 1; x0 = 1; y0 = 2; x1 = 10; y1 = 20; c0 = ADD; c1 = ADD;
    cycle();
    check("rr_first", gid, 0);
    repeat (3) cycle();
    check("rr_second", gid, 1);
    repeat (3) cycle();
    check("rr_third", gid, 0);
    keep0 = 0; keep1 = 0; v0 = 0; v1 = 0;
    repeat (2) cycle();
    // backpressure on requester 0
    rr0 = 0; v0 = 1; x0 = 16'h1234; y0 = 16'h0101; c0 = ADD;
    cycle();
    v1 = 1; x1 = 7; y1 = 7; c1 = SUB;
    cycle();
    hold = out0;
    check("bp_hold_val", hold, 16'h1335);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("bp_stable", out0, hold);
      check("bp_rdy1", rdy1, 0);
      check("bp_busy", busy, 1);
    end
    rr0 = 1; rr1 = 1;
    repeat (4) cycle();
    // zero op and wraparound
    v0 = 1; x0 = 16'($urandom); y0 = 16'($urandom); c0 = ZERO;
    cycle(); cycle();
    check("zero_out", out0, 0);
    check("zero_zr", zr0, 1);
    check("zero_ng", ng0, 0);
    cycle();
    v0 = 1; x0 = 16'hFFFF; y0 = 1; c0 = ADD;
    cycle(); cycle();
    check("wrap_out", out0, 0);
    check("wrap_zr", zr0, 1);
    cycle();
    // reset while the operation is in EXEC
    v0 = 1; x0 = 2; y0 = 2; c0 = ADD;
    cycle();
    check("exec_busy", busy, 1);
    do_reset();
    cycle();
    check("post_rst_idle", busy, 0);
    v0 = 1; v1 = 1; x0 = 7; y0 = 9; x1 = 1; y1 = 1; c0 = ADD; c1 = ADD;
    cycle();
    check("post_rst_gnt", gid, 0);
    repeat (2) cycle();
    repeat (4) cycle();
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!v0 && $urandom_range(0, 2) == 0) begin
        v0 = 1; x0 = 16'($urandom); y0 = 16'($urandom);
        c0 = $urandom_range(0, 1) ? 6'($urandom) : (n % 2 ? SUB : ADD);
      end
      if (!v1 && $urandom_range(0, 2) == 0) begin
        v1 = 1; x1 = 16'($urandom); y1 = 16'($urandom); c1 = 6'($urandom);
      end
      rr0 = 1'($urandom);
      rr1 = 1'($urandom);
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 16, datapath width, fixed at 16 for the Hack ALU.
REQ-002 The block SHALL have parameter RR_INIT, default 0, the requester index favoured first after reset.
Ports:
REQ-003 The block SHALL have port clk, input, 1, the single clock; all flops rise on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 For each requester i in {0,1}, the block SHALL have port req<i>_valid, input, 1, operation offered.
REQ-006 For each requester i, the block SHALL have port req<i>_ready, output, 1, operation accepted this cycle.
REQ-007 For each requester i, the block SHALL have ports req<i>_x and req<i>_y, input, WIDTH, operands.
REQ-008 For each requester i, the block SHALL have port req<i>_ctrl, input, 6, ALU control {zx,nx,zy,ny,f,no}, with bit5 = zx and bit0 = no.
REQ-009 For each requester i, the block SHALL have port rsp<i>_valid, output, 1, result available.
REQ-010 For each requester i, the block SHALL have port rsp<i>_ready, input, 1, result consumed.
REQ-011 For each requester i, the block SHALL have ports rsp<i>_out (output, WIDTH), rsp<i>_zr (output, 1) and rsp<i>_ng (output, 1), the result and its flags.
REQ-012 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-013 The block SHALL have port grant_id, output, 1, the index of the requester currently owning the ALU.

Function
REQ-014 The block SHALL implement FSM states IDLE, EXEC and RESP, with IDLE as the reset state.
REQ-015 In IDLE with exactly one reqN_valid high, the block SHALL grant that requester regardless of the round-robin pointer.
REQ-016 In IDLE with both reqN_valid high, the block SHALL grant the requester named by the round-robin pointer.
REQ-017 reqN_ready SHALL be combinational: (state==IDLE) && granted==N && reqN_valid; at most one ready SHALL be high per cycle.
REQ-018 On the accept cycle, the block SHALL latch x, y, ctrl and grant_id into operand registers and SHALL move to EXEC.
REQ-019 In EXEC, the shared ALU SHALL evaluate the latched operands; out, zr and ng SHALL be registered into the result register, and the FSM SHALL move to RESP.
REQ-020 In RESP, rsp<grant_id>_valid SHALL be high and the other rsp_valid SHALL be low; payload SHALL be stable while valid.
REQ-021 When RESP is active and rsp<grant_id>_ready is high, the handshake SHALL complete that cycle, the pointer SHALL become ~grant_id, and the FSM SHALL return to IDLE.
REQ-022 Latency SHALL be: accept at cycle N, rsp_valid rising at N+2; peak throughput SHALL be one operation per 3 cycles.
REQ-023 rsp_ready held high before rsp_valid rises SHALL complete the handshake on the first RESP cycle.
REQ-024 The block SHALL hold reqN_ready low while busy; requesters SHALL keep valid and payload stable until ready.
REQ-025 The block SHALL ignore rsp_ready of the non-granted requester.
REQ-026 Arithmetic SHALL be modulo 2^16 (add carry discarded); zr SHALL equal (out==0); ng SHALL equal out[15].

Reset
REQ-027 While rst_n is low, the block SHALL force: state=IDLE, pointer=RR_INIT, grant_id=0, busy=0, both rsp_valid=0, result and operand registers=0.
REQ-028 A reset asserted in EXEC or RESP SHALL drop the in-flight operation with no response.
REQ-029 The first post-reset acceptance SHALL occur no earlier than the first clk edge after rst_n rises.

Structure
REQ-030 Shared package alu_pkg SHALL hold: ctrl bit-index constants, the state enum (IDLE/EXEC/RESP), and named Hack op codes (e.g. ADD=6'b000010, SUB=6'b010011, ZERO=6'b101010).
REQ-031 The block SHALL instantiate exactly one alu_optimized sub-module, fed only from the operand registers.

Verification
REQ-032 The bench SHALL check: after reset, req0 x=5, y=3, ctrl=000010 -> req0_ready the same cycle; rsp0_valid 2 cycles later with out=8, zr=0, ng=0.
REQ-033 The bench SHALL check: req1 x=3, y=5, ctrl=010011 -> rsp1_out=16'hFFFE, ng=1, zr=0; rsp0_valid stays 0.
REQ-034 The bench SHALL check: both valid at once after reset (RR_INIT=0) -> req0 served first, then req1; with both still valid, the next grant returns to req0.
REQ-035 The bench SHALL check: rsp0_ready low for 4 cycles in RESP -> rsp0_valid and payload stable, req1_ready stays 0, busy=1 throughout.
REQ-036 The bench SHALL check: ctrl=101010 with any x, y -> out=0, zr=1, ng=0; x=16'hFFFF, y=1, ctrl=000010 -> out=0, zr=1.
REQ-037 The bench SHALL check: rst_n pulsed low during EXEC -> immediate IDLE, no rsp_valid, pointer=RR_INIT, next request served normally.
